mem_req_queue: RTL and testbench

- Small in-order FIFO of memory operations between the execute stage and the data-cache interface.
- Accepts load/store/AMO requests from the pipeline and presents them to the cache interface one at a time.
- Holds the head entry until it is completed, re-presents it on a nack, and flushes everything on a kill or exception.
- Decouples the pipeline from cache back-pressure, so execute is not stalled for the full cache round trip.

---
 rtl/mem_req_queue.sv | 128 ++++++++++++
 tb/tb_mem_req_queue.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_queue.sv
// In-order memory request queue between execute and the data-cache interface.
// Holds the head until completed, replays on nack, flushes on kill/exception.
module mem_req_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned MAX_RETRY = 15
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     enq_valid_i,
    output logic                     enq_ready_o,
    input  logic [63:0]              enq_base_i,
    input  logic [63:0]              enq_imm_i,
    input  logic [63:0]              enq_data_i,
    input  logic [6:0]               enq_instr_type_i,
    input  logic [2:0]               enq_mem_size_i,
    input  logic [4:0]               enq_rd_i,
    input  logic                     kill_i,
    output logic                     issue_valid_o,
    output logic [63:0]              issue_base_o,
    output logic [63:0]              issue_imm_o,
    output logic [63:0]              issue_data_o,
    output logic [6:0]               issue_instr_type_o,
    output logic [2:0]               issue_mem_size_o,
    output logic [4:0]               issue_rd_o,
    input  logic                     busy_i,
    input  logic                     done_i,
    input  logic                     nack_i,
    input  logic                     xcpt_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [3:0]               retry_cnt_o,
    output logic                     in_flight_o
);

    localparam int unsigned PtrW   = $clog2(DEPTH);
    localparam int unsigned CntW   = PtrW + 1;
    localparam int unsigned EntryW = 64 + 64 + 64 + 7 + 3 + 5;

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e            state_q;
    logic [PtrW-1:0]   wr_q, rd_q;
    logic [CntW-1:0]   count_q;
    logic [3:0]        retry_q;
    logic              in_flight_q;
    logic [EntryW-1:0] mem_q [DEPTH];

    logic              flush, push, pop;
    logic [EntryW-1:0] enq_entry;

    assign enq_entry = {enq_base_i, enq_imm_i, enq_data_i, enq_instr_type_i,
                        enq_mem_size_i, enq_rd_i};

    assign {issue_base_o, issue_imm_o, issue_data_o, issue_instr_type_o,
            issue_mem_size_o, issue_rd_o} = mem_q[rd_q];

    // Ready looks only at current occupancy: a full queue refuses even while popping.
    assign enq_ready_o   = (count_q != CntW'(DEPTH));
    assign issue_valid_o = (state_q == StIdle) && (count_q != '0) && !kill_i;

    assign flush = kill_i || ((state_q == StWait) && xcpt_i);
    assign push  = enq_valid_i && enq_ready_o && !flush;
    assign pop   = (state_q == StWait) && !flush && done_i;

    assign count_o     = count_q;
    assign retry_cnt_o = retry_q;
    assign in_flight_o = in_flight_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= StIdle;
            wr_q        <= '0;
            rd_q        <= '0;
            count_q     <= '0;
            retry_q     <= '0;
            in_flight_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            state_q     <= StIdle;
            wr_q        <= '0;
            rd_q        <= '0;
            count_q     <= '0;
            retry_q     <= '0;
            in_flight_q <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= enq_entry;
                wr_q        <= wr_q + PtrW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + PtrW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CntW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CntW'(1);
            end

            unique case (state_q)
                StIdle: begin
                    if (issue_valid_o && !busy_i) begin
                        state_q     <= StWait;
                        in_flight_q <= 1'b1;
                    end
                end
                StWait: begin
                    if (done_i) begin
                        state_q     <= StIdle;
                        in_flight_q <= 1'b0;
                        retry_q     <= '0;
                    end else if (nack_i) begin
                        state_q     <= StIdle;
                        in_flight_q <= 1'b0;
                        if (retry_q < 4'(MAX_RETRY)) begin
                            retry_q <= retry_q + 4'd1;
                        end
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    in_flight_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_queue.sv
// Self-checking bench for mem_req_queue: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_mem_req_queue;

    localparam int unsigned DEPTH     = 4;
    localparam int unsigned MAX_RETRY = 15;

    typedef struct packed {
        logic [63:0] base;
        logic [63:0] imm;
        logic [63:0] data;
        logic [6:0]  typ;
        logic [2:0]  size;
        logic [4:0]  rd;
    } ent_t;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        enq_valid_i, enq_ready_o;
    logic [63:0] enq_base_i, enq_imm_i, enq_data_i;
    logic [6:0]  enq_instr_type_i;
    logic [2:0]  enq_mem_size_i;
    logic [4:0]  enq_rd_i;
    logic        kill_i;
    logic        issue_valid_o;
    logic [63:0] issue_base_o, issue_imm_o, issue_data_o;
    logic [6:0]  issue_instr_type_o;
    logic [2:0]  issue_mem_size_o;
    logic [4:0]  issue_rd_o;
    logic        busy_i, done_i, nack_i, xcpt_i;
    logic [2:0]  count_o;
    logic [3:0]  retry_cnt_o;
    logic        in_flight_o;

    int checks   = 0;
    int failures = 0;

    mem_req_queue #(.DEPTH(DEPTH), .MAX_RETRY(MAX_RETRY)) dut (
        .clk_i              (clk_i),
        .rstn_i             (rstn_i),
        .enq_valid_i        (enq_valid_i),
        .enq_ready_o        (enq_ready_o),
        .enq_base_i         (enq_base_i),
        .enq_imm_i          (enq_imm_i),
        .enq_data_i         (enq_data_i),
        .enq_instr_type_i   (enq_instr_type_i),
        .enq_mem_size_i     (enq_mem_size_i),
        .enq_rd_i           (enq_rd_i),
        .kill_i             (kill_i),
        .issue_valid_o      (issue_valid_o),
        .issue_base_o       (issue_base_o),
        .issue_imm_o        (issue_imm_o),
        .issue_data_o       (issue_data_o),
        .issue_instr_type_o (issue_instr_type_o),
        .issue_mem_size_o   (issue_mem_size_o),
        .issue_rd_o         (issue_rd_o),
        .busy_i             (busy_i),
        .done_i             (done_i),
        .nack_i             (nack_i),
        .xcpt_i             (xcpt_i),
        .count_o            (count_o),
        .retry_cnt_o        (retry_cnt_o),
        .in_flight_o        (in_flight_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic ent_t rand_ent();
        ent_t e;
        e.base = {$urandom, $urandom};
        e.imm  = {$urandom, $urandom};
        e.data = {$urandom, $urandom};
        e.typ  = 7'($urandom);
        e.size = 3'($urandom);
        e.rd   = 5'($urandom);
        return e;
    endfunction

    function automatic ent_t head();
        return {issue_base_o, issue_imm_o, issue_data_o, issue_instr_type_o,
                issue_mem_size_o, issue_rd_o};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_enq(input logic v, input ent_t e);
        enq_valid_i      = v;
        enq_base_i       = e.base;
        enq_imm_i        = e.imm;
        enq_data_i       = e.data;
        enq_instr_type_i = e.typ;
        enq_mem_size_i   = e.size;
        enq_rd_i         = e.rd;
    endtask

    task automatic clear_inputs();
        set_enq(1'b0, '0);
        kill_i = 0; busy_i = 0; done_i = 0; nack_i = 0; xcpt_i = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rstn_i = 1'b0;
        tick();
        tick();
        rstn_i = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        rstn_i = 1'b0;
        #3;
        checks++; if (issue_valid_o !== 1'b0) begin failures++;
            $display("FAIL reset_issue_valid got %b want 0", issue_valid_o); end
        checks++; if (enq_ready_o !== 1'b1) begin failures++;
            $display("FAIL reset_enq_ready got %b want 1", enq_ready_o); end
        checks++; if (count_o !== 3'd0) begin failures++;
            $display("FAIL reset_count got %0d want 0", count_o); end
        checks++; if (retry_cnt_o !== 4'd0) begin failures++;
            $display("FAIL reset_retry got %0d want 0", retry_cnt_o); end
        checks++; if (in_flight_o !== 1'b0) begin failures++;
            $display("FAIL reset_in_flight got %b want 0", in_flight_o); end
        tick();
        rstn_i = 1'b1;
        tick();
    endtask

    task automatic test_single_op();
        ent_t e;
        e = rand_ent();
        e.base = 64'h1000; e.imm = 64'h8; e.rd = 5'd5;
        set_enq(1'b1, e);
        tick();
        set_enq(1'b0, '0);
        #1;
        checks++; if (issue_valid_o !== 1'b1 || head() !== e) begin failures++;
            $display("FAIL single_issue got v=%b rd=%0d base=%h want v=1 rd=5 base=1000",
                     issue_valid_o, issue_rd_o, issue_base_o); end
        tick();
        checks++; if (in_flight_o !== 1'b1 || issue_valid_o !== 1'b0) begin failures++;
            $display("FAIL single_in_flight got if=%b v=%b want if=1 v=0",
                     in_flight_o, issue_valid_o); end
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        #1;
        checks++; if (count_o !== 3'd0 || issue_valid_o !== 1'b0 || in_flight_o !== 1'b0) begin
            failures++;
            $display("FAIL single_done got cnt=%0d v=%b if=%b want 0 0 0",
                     count_o, issue_valid_o, in_flight_o); end
    endtask

    task automatic test_back_pressure();
        ent_t e [5];
        busy_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            e[i] = rand_ent();
            e[i].rd = 5'(10 + i);
            set_enq(1'b1, e[i]);
            #1;
            if (i == 4) begin
                checks++; if (enq_ready_o !== 1'b0) begin failures++;
                    $display("FAIL bp_ready_full got %b want 0", enq_ready_o); end
            end
            tick();
        end
        set_enq(1'b0, '0);
        tick();
        checks++; if (count_o !== 3'd4 || issue_valid_o !== 1'b1 || head() !== e[0]) begin
            failures++;
            $display("FAIL bp_hold got cnt=%0d v=%b rd=%0d want cnt=4 v=1 rd=%0d",
                     count_o, issue_valid_o, issue_rd_o, e[0].rd); end
        busy_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (issue_valid_o !== 1'b1 || head() !== e[k]) begin failures++;
                $display("FAIL bp_order[%0d] got v=%b rd=%0d want v=1 rd=%0d",
                         k, issue_valid_o, issue_rd_o, e[k].rd); end
            tick();
            done_i = 1'b1;
            tick();
            done_i = 1'b0;
        end
        #1;
        checks++; if (count_o !== 3'd0) begin failures++;
            $display("FAIL bp_drained got %0d want 0", count_o); end
    endtask

    task automatic test_nack();
        ent_t e;
        e = rand_ent();
        e.rd = 5'd7;
        set_enq(1'b1, e);
        tick();
        set_enq(1'b0, '0);
        for (int n = 0; n < 3; n++) begin
            #1;
            checks++; if (issue_valid_o !== 1'b1 || head() !== e) begin failures++;
                $display("FAIL nack_reissue[%0d] got v=%b rd=%0d want v=1 rd=7",
                         n, issue_valid_o, issue_rd_o); end
            tick();
            nack_i = 1'b1;
            tick();
            nack_i = 1'b0;
            #1;
            checks++; if (retry_cnt_o !== 4'(n + 1)) begin failures++;
                $display("FAIL nack_retry[%0d] got %0d want %0d", n, retry_cnt_o, n + 1); end
        end
        tick();
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        #1;
        checks++; if (retry_cnt_o !== 4'd0 || count_o !== 3'd0) begin failures++;
            $display("FAIL nack_done got retry=%0d cnt=%0d want 0 0", retry_cnt_o, count_o); end
        set_enq(1'b1, rand_ent());
        tick();
        set_enq(1'b0, '0);
        repeat (20) begin
            tick();
            nack_i = 1'b1;
            tick();
            nack_i = 1'b0;
        end
        #1;
        checks++; if (retry_cnt_o !== 4'(MAX_RETRY)) begin failures++;
            $display("FAIL nack_saturate got %0d want %0d", retry_cnt_o, MAX_RETRY); end
        kill_i = 1'b1;
        tick();
        kill_i = 1'b0;
        #1;
        checks++; if (count_o !== 3'd0 || retry_cnt_o !== 4'd0) begin failures++;
            $display("FAIL nack_kill got cnt=%0d retry=%0d want 0 0", count_o, retry_cnt_o); end
    endtask

    task automatic test_kill();
        for (int i = 0; i < 3; i++) begin
            set_enq(1'b1, rand_ent());
            tick();
        end
        #1;
        checks++; if (count_o !== 3'd3 || in_flight_o !== 1'b1) begin failures++;
            $display("FAIL kill_setup got cnt=%0d if=%b want 3 1", count_o, in_flight_o); end
        kill_i = 1'b1;
        #1;
        checks++; if (issue_valid_o !== 1'b0) begin failures++;
            $display("FAIL kill_issue_comb got %b want 0", issue_valid_o); end
        tick();
        kill_i = 1'b0;
        set_enq(1'b0, '0);
        #1;
        checks++; if (count_o !== 3'd0 || in_flight_o !== 1'b0 || issue_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL kill_flush got cnt=%0d if=%b v=%b want 0 0 0",
                     count_o, in_flight_o, issue_valid_o); end
    endtask

    task automatic test_xcpt();
        set_enq(1'b1, rand_ent());
        tick();
        set_enq(1'b1, rand_ent());
        tick();
        set_enq(1'b0, '0);
        #1;
        checks++; if (in_flight_o !== 1'b1 || count_o !== 3'd2) begin failures++;
            $display("FAIL xcpt_setup got if=%b cnt=%0d want 1 2", in_flight_o, count_o); end
        xcpt_i = 1'b1;
        done_i = 1'b1;
        tick();
        xcpt_i = 1'b0;
        done_i = 1'b0;
        #1;
        checks++; if (count_o !== 3'd0 || in_flight_o !== 1'b0) begin failures++;
            $display("FAIL xcpt_flush got cnt=%0d if=%b want 0 0", count_o, in_flight_o); end
    endtask

    task automatic test_wrap();
        ent_t e [10];
        int   sent = 0;
        int   recv = 0;
        int   cyc  = 0;
        for (int i = 0; i < 10; i++) begin
            e[i] = rand_ent();
            e[i].rd = 5'(i + 1);
        end
        while (recv < 10 && cyc < 200) begin
            if (sent < 10) set_enq(1'b1, e[sent]);
            else set_enq(1'b0, '0);
            done_i = in_flight_o;
            #1;
            if (issue_valid_o) begin
                checks++; if (head() !== e[recv]) begin failures++;
                    $display("FAIL wrap_order[%0d] got rd=%0d data=%h want rd=%0d data=%h",
                             recv, issue_rd_o, issue_data_o, e[recv].rd, e[recv].data); end
            end
            if (enq_valid_i && enq_ready_o) sent++;
            if (done_i) recv++;
            cyc++;
            tick();
        end
        clear_inputs();
        #1;
        checks++; if (recv != 10 || count_o !== 3'd0) begin failures++;
            $display("FAIL wrap_complete got recv=%0d cnt=%0d want 10 0", recv, count_o); end
    endtask

    task automatic test_async_reset();
        busy_i = 1'b1;
        set_enq(1'b1, rand_ent());
        tick();
        tick();
        set_enq(1'b0, '0);
        #2;
        rstn_i = 1'b0;
        #1;
        checks++; if (count_o !== 3'd0 || issue_valid_o !== 1'b0 || enq_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL async_reset got cnt=%0d v=%b rdy=%b want 0 0 1",
                     count_o, issue_valid_o, enq_ready_o); end
        tick();
        rstn_i = 1'b1;
        clear_inputs();
        tick();
    endtask

    task automatic test_random();
        ent_t q [$];
        bit   waiting = 0;
        int   retry   = 0;
        bit   ev, er;
        int   r;
        int   bad     = 0;
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            set_enq(1'($urandom_range(0, 1)), rand_ent());
            busy_i = ($urandom_range(0, 3) == 0);
            r      = $urandom_range(0, 9);
            done_i = (r < 4);
            nack_i = (r >= 4 && r < 7);
            xcpt_i = ($urandom_range(0, 24) == 0);
            kill_i = ($urandom_range(0, 39) == 0);
            #1;
            er = (q.size() != DEPTH);
            ev = !waiting && q.size() != 0 && !kill_i;
            if (bad < 10) begin
                checks++; if (count_o !== 3'(q.size()) || enq_ready_o !== er) begin
                    failures++; bad++;
                    $display("FAIL rand_count c=%0d got cnt=%0d rdy=%b want cnt=%0d rdy=%b",
                             c, count_o, enq_ready_o, q.size(), er); end
                checks++; if (issue_valid_o !== ev || in_flight_o !== waiting) begin
                    failures++; bad++;
                    $display("FAIL rand_state c=%0d got v=%b if=%b want v=%b if=%b",
                             c, issue_valid_o, in_flight_o, ev, waiting); end
                checks++; if (retry_cnt_o !== 4'(retry)) begin failures++; bad++;
                    $display("FAIL rand_retry c=%0d got %0d want %0d", c, retry_cnt_o, retry); end
                if (ev) begin
                    checks++; if (head() !== q[0]) begin failures++; bad++;
                        $display("FAIL rand_head c=%0d got rd=%0d want rd=%0d",
                                 c, issue_rd_o, q[0].rd); end
                end
            end
            if (kill_i || (waiting && xcpt_i)) begin
                q.delete();
                waiting = 0;
                retry   = 0;
            end else begin
                if (waiting && done_i) begin
                    void'(q.pop_front());
                    waiting = 0;
                    retry   = 0;
                end else if (waiting && nack_i) begin
                    waiting = 0;
                    retry   = (retry < MAX_RETRY) ? retry + 1 : retry;
                end else if (!waiting && ev && !busy_i) begin
                    waiting = 1;
                end
                if (enq_valid_i && er) begin
                    q.push_back('{enq_base_i, enq_imm_i, enq_data_i, enq_instr_type_i,
                                  enq_mem_size_i, enq_rd_i});
                end
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_back_pressure();
        test_nack();
        test_kill();
        test_xcpt();
        test_wrap();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
